// File: rtl/card_board_ctrl.sv
// Memory-game board controller: owns layout and card states, builds the formato_bus words (CARD_PEEK_EN adds reveal masking).
// Latency: a pick shows after its edge; compare resolves on the next edge; a mismatch hides HOLD_CYCLES+1 edges after the second pick.
// Backpressure: sel_ready is high only in IDLE/ONE; picks of invalid or already-revealed cards are accepted and dropped.
module card_board_ctrl #(
  parameter int NCARDS      = 16,
  parameter int HOLD_CYCLES = 25_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [NCARDS*3-1:0]   layout,
  input  logic                  sel_valid,
  input  logic [3:0]            sel_idx,
  output logic                  sel_ready,
  input  logic                  peek,
  output logic [NCARDS*5-1:0]   formato_bus,
  output logic [3:0]            pairs_found,
  output logic [7:0]            turns,
  output logic                  game_done
);

  localparam int CW = $clog2(HOLD_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, ONE, CHECK, WAIT, DONE} state_t;

  state_t                state_q, state_d;
  logic [NCARDS*3-1:0]   layout_q;
  logic [2*NCARDS-1:0]   card_st;
  logic [3:0]            idx_a, idx_b;
  logic [CW-1:0]         hold_cnt;
  logic [3:0]            pairs_q;
  logic [7:0]            turns_q;

  logic [1:0]            pick_st;
  logic [2:0]            sym_a, sym_b;
  logic                  pick_ok, sym_eq, hold_end, last_pair, peek_on;

  // Out-of-range indices keep pick_st at 11, which never qualifies as hidden.
  always_comb begin
    pick_st = 2'b11;
    sym_a   = 3'd0;
    sym_b   = 3'd0;
    for (int i = 0; i < NCARDS; i++) begin
      if (sel_idx == 4'(i)) pick_st = card_st[2*i +: 2];
      if (idx_a == 4'(i))   sym_a   = layout_q[3*i +: 3];
      if (idx_b == 4'(i))   sym_b   = layout_q[3*i +: 3];
    end
  end

  assign pick_ok   = sel_valid && sel_ready && (pick_st == 2'b00);
  assign sym_eq    = (sym_a == sym_b);
  assign hold_end  = (hold_cnt == CW'(HOLD_CYCLES - 1));
  assign last_pair = (pairs_q == 4'(NCARDS / 2 - 1));

  always_comb begin
    state_d   = state_q;
    sel_ready = 1'b0;
    case (state_q)
      IDLE: begin
        sel_ready = 1'b1;
        if (pick_ok) state_d = ONE;
      end
      ONE: begin
        sel_ready = 1'b1;
        if (pick_ok) state_d = CHECK;
      end
      CHECK: begin
        if (!sym_eq)        state_d = WAIT;
        else if (last_pair) state_d = DONE;
        else                state_d = IDLE;
      end
      WAIT:    if (hold_end) state_d = IDLE;
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
    if (load) state_d = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      layout_q <= '0;
      card_st  <= '0;
      idx_a    <= 4'd0;
      idx_b    <= 4'd0;
      hold_cnt <= '0;
      pairs_q  <= 4'd0;
      turns_q  <= 8'd0;
    end else if (load) begin
      layout_q <= layout;
      card_st  <= '0;
      hold_cnt <= '0;
      pairs_q  <= 4'd0;
      turns_q  <= 8'd0;
    end else begin
      case (state_q)
        IDLE, ONE: begin
          if (pick_ok) begin
            for (int i = 0; i < NCARDS; i++)
              if (sel_idx == 4'(i)) card_st[2*i +: 2] <= 2'b01;
            if (state_q == IDLE) idx_a <= sel_idx;
            else                 idx_b <= sel_idx;
          end
        end
        CHECK: begin
          if (turns_q != 8'hFF) turns_q <= turns_q + 8'd1;
          if (sym_eq) begin
            for (int i = 0; i < NCARDS; i++)
              if (idx_a == 4'(i) || idx_b == 4'(i)) card_st[2*i +: 2] <= 2'b10;
            pairs_q <= pairs_q + 4'd1;
          end else begin
            hold_cnt <= '0;
          end
        end
        WAIT: begin
          hold_cnt <= hold_cnt + CW'(1);
          if (hold_end)
            for (int i = 0; i < NCARDS; i++)
              if (idx_a == 4'(i) || idx_b == 4'(i)) card_st[2*i +: 2] <= 2'b00;
        end
        default: ;
      endcase
    end
  end

`ifdef CARD_PEEK_EN
  assign peek_on = peek;
`else
  logic unused_peek;
  assign unused_peek = peek;
  assign peek_on     = 1'b0;
`endif

  // Peek only masks the output view; stored states stay untouched.
  for (genvar g = 0; g < NCARDS; g++) begin : g_fmt
    assign formato_bus[5*g +: 5] = {layout_q[3*g +: 3],
        (peek_on && card_st[2*g +: 2] == 2'b00) ? 2'b10 : card_st[2*g +: 2]};
  end

  assign pairs_found = pairs_q;
  assign turns       = turns_q;
  assign game_done   = (state_q == DONE);

endmodule
